// File: rtl/scarv_cop_fu_dispatch_if.sv
// Dispatcher handshake bundle: decoded-instruction issue, functional-unit ivalid/idone, completion response, debug read.
// The slave modport is the dispatcher; the master modport is the host core plus functional unit.
interface scarv_cop_fu_dispatch_if;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_crs1;
    logic [3:0]  id_crs2;
    logic [3:0]  id_crs3;
    logic [3:0]  id_crd;
    logic        id_wb;
    logic        fu_ivalid;
    logic        fu_idone;
    logic [31:0] fu_rs1;
    logic [31:0] fu_rs2;
    logic [31:0] fu_rs3;
    logic [3:0]  fu_rd_ben;
    logic [31:0] fu_rd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport slave (
        input  id_valid, id_crs1, id_crs2, id_crs3, id_crd, id_wb,
        input  fu_idone, fu_rd_ben, fu_rd_wdata, rsp_ready, dbg_addr,
        output id_ready, fu_ivalid, fu_rs1, fu_rs2, fu_rs3,
        output rsp_valid, rsp_status, dbg_data
    );

    modport master (
        output id_valid, id_crs1, id_crs2, id_crs3, id_crd, id_wb,
        output fu_idone, fu_rd_ben, fu_rd_wdata, rsp_ready, dbg_addr,
        input  id_ready, fu_ivalid, fu_rs1, fu_rs2, fu_rs3,
        input  rsp_valid, rsp_status, dbg_data
    );
endinterface

// File: rtl/scarv_cop_fu_dispatch.sv
// Issues one coprocessor instruction at a time to a functional unit and commits its byte-enabled result to a 16x32 CPR file.
// Accept to rsp_valid is 2 edges for a single-cycle unit; rsp_valid holds until rsp_ready, and id_ready returns one cycle after the response handshake.
module scarv_cop_fu_dispatch #(
    parameter int          FU_TIMEOUT = 15,
    parameter logic [31:0] CPR_RESET  = 32'h0
) (
    input logic                    g_clk,
    input logic                    g_reset,
    scarv_cop_fu_dispatch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(FU_TIMEOUT - 1);

    state_t      state;
    logic [31:0] cpr [16];
    logic [3:0]  crd;
    logic        wb;
    logic [7:0]  cnt;
    logic        id_ready;
    logic        fu_ivalid;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] fu_rs1;
    logic [31:0] fu_rs2;
    logic [31:0] fu_rs3;

    assign bus.id_ready   = id_ready;
    assign bus.fu_ivalid  = fu_ivalid;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_status = rsp_status;
    assign bus.fu_rs1     = fu_rs1;
    assign bus.fu_rs2     = fu_rs2;
    assign bus.fu_rs3     = fu_rs3;
    assign bus.dbg_data   = cpr[bus.dbg_addr];

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state      <= IDLE;
            for (int i = 0; i < 16; i++) cpr[i] <= CPR_RESET;
            crd        <= '0;
            wb         <= 1'b0;
            cnt        <= '0;
            id_ready   <= 1'b1;
            fu_ivalid  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'b00;
            fu_rs1     <= '0;
            fu_rs2     <= '0;
            fu_rs3     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.id_valid) begin
                        fu_rs1    <= cpr[bus.id_crs1];
                        fu_rs2    <= cpr[bus.id_crs2];
                        fu_rs3    <= cpr[bus.id_crs3];
                        crd       <= bus.id_crd;
                        wb        <= bus.id_wb;
                        cnt       <= '0;
                        id_ready  <= 1'b0;
                        fu_ivalid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // idone takes priority over a coincident timeout
                    if (bus.fu_idone) begin
                        if (wb) begin
                            for (int b = 0; b < 4; b++) begin
                                if (bus.fu_rd_ben[b]) cpr[crd][8*b +: 8] <= bus.fu_rd_wdata[8*b +: 8];
                            end
                        end
                        rsp_status <= 2'b00;
                        fu_ivalid  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_status <= 2'b01;
                        fu_ivalid  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_status <= 2'b00;
                        id_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
